// File: rtl/isa_tx_arbiter_if.sv
// Outbound ring write-side bundle: requester handshakes in, ring write port
// and status out. The master side drives requests and the ring read pointer.
interface isa_tx_arbiter_if #(
    parameter int N  = 4,
    parameter int AW = 13
);
    localparam int GW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    in_valid;
    logic [9*N-1:0]  in_data;
    logic [N-1:0]    in_ready;
    logic [AW-1:0]   rd_ptr;
    logic            o_we;
    logic [AW-1:0]   o_addr;
    logic [8:0]      o_data;
    logic            tx_pending;
    logic [AW-1:0]   level;
    logic [GW-1:0]   grant_id;
    logic            lock_err;

    modport master (
        output in_valid, in_data, rd_ptr,
        input  in_ready, o_we, o_addr, o_data, tx_pending, level, grant_id, lock_err
    );

    modport slave (
        input  in_valid, in_data, rd_ptr,
        output in_ready, o_we, o_addr, o_data, tx_pending, level, grant_id, lock_err
    );
endinterface

// File: rtl/isa_tx_arbiter.sv
// isa_tx_arbiter: merges the tagged 9-bit word streams of the ISA device
// emulations into the single write port of the outbound ring. Round-robin
// between requesters, with a lock that keeps an address marker and its data
// byte on consecutive ring addresses.

// One-entry holding slot per requester.
module isa_tx_slot (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [8:0] load_word,
    input  logic       drain,
    output logic       full,
    output logic [8:0] word
);
    // Drain wins; a slot only loads while empty, so it cannot refill on its drain cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            word <= '0;
        end else if (drain) begin
            full <= 1'b0;
        end else if (load && !full) begin
            full <= 1'b1;
            word <= load_word;
        end
    end
endmodule

module isa_tx_arbiter #(
    parameter int N            = 4,
    parameter int AW           = 13,
    parameter int LOCK_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    isa_tx_arbiter_if.slave bus
);
    localparam int GW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = GW + 1;
    localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [KW-1:0] N_W      = KW'(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);

    typedef struct packed {
        logic       marker;
        logic [7:0] payload;
    } isa_word_t;

    typedef enum logic {ST_FREE, ST_LOCKED} lock_state_t;

    // slot array
    logic [N-1:0]      slot_full;
    logic [N-1:0][8:0] slot_word;
    logic [N-1:0]      drain;

    // ring / arbiter state
    logic [AW-1:0] wr_ptr;
    logic [GW-1:0] rr_ptr;
    lock_state_t   lock_q, lock_d;
    logic [GW-1:0] owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_d;

    // registered outputs
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [8:0]    data_q;
    logic [GW-1:0] gid_q;
    logic          err_q;
    logic          pend_q;
    logic [AW-1:0] level_q;

    // grant decode
    logic          ring_full;
    logic [N-1:0]  owner_mask;
    logic [N-1:0]  cand;
    logic          gnt_any;
    logic          gnt_valid;
    logic [GW-1:0] gnt_id;
    logic [KW-1:0] idx;
    logic [KW-1:0] rr_nx;
    logic [GW-1:0] next_rr;
    isa_word_t     gnt_word;

    for (genvar i = 0; i < N; i++) begin : g_slot
        isa_tx_slot u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (bus.in_valid[i]),
            .load_word (bus.in_data[9*i +: 9]),
            .drain     (drain[i]),
            .full      (slot_full[i]),
            .word      (slot_word[i])
        );
    end

    // Full test uses the sampled rd_ptr: one slot is always left unused
    assign ring_full = ((wr_ptr + AW'(1)) == bus.rd_ptr);

    // Round-robin pick from rr_ptr upward; while locked only the owner may win
    always_comb begin
        owner_mask          = '0;
        owner_mask[owner_q] = 1'b1;
        cand                = (lock_q == ST_LOCKED) ? (slot_full & owner_mask) : slot_full;
        gnt_any             = 1'b0;
        gnt_id              = '0;
        idx                 = '0;
        // descending scan so the smallest offset from rr_ptr is the last hit
        for (int k = N - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + KW'(k);
            if (idx >= N_W) idx = idx - N_W;
            if (cand[idx[GW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = idx[GW-1:0];
            end
        end
        gnt_valid = gnt_any && !ring_full;
        gnt_word  = isa_word_t'(slot_word[gnt_id]);
        drain     = '0;
        for (int i = 0; i < N; i++) begin
            drain[i] = gnt_valid && (gnt_id == GW'(i));
        end
        rr_nx = {1'b0, gnt_id} + KW'(1);
        if (rr_nx >= N_W) rr_nx = '0;
        next_rr = rr_nx[GW-1:0];
    end

    // Lock state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q  <= ST_FREE;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lock next state: markers take/refresh the lock, the owner's data byte
    // releases it, and an owner that goes quiet too long is dropped
    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        if (gnt_valid && gnt_word.marker) begin
            lock_d  = ST_LOCKED;
            owner_d = gnt_id;
            cnt_d   = '0;
        end else if (lock_q == ST_LOCKED) begin
            if (gnt_valid) begin
                // while locked a grant can only be the owner's data byte
                lock_d = ST_FREE;
                cnt_d  = '0;
            end else if (!slot_full[owner_q]) begin
                if (cnt_q == CNT_LAST) begin
                    lock_d = ST_FREE;
                    cnt_d  = '0;
                    err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    // Ring write port, pointers and status; status reflects wr_ptr before this cycle's write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rr_ptr  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            gid_q   <= '0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            level_q <= '0;
        end else begin
            we_q    <= gnt_valid;
            err_q   <= err_d;
            pend_q  <= (wr_ptr != bus.rd_ptr);
            level_q <= wr_ptr - bus.rd_ptr;
            if (gnt_valid) begin
                addr_q <= wr_ptr;
                data_q <= gnt_word;
                gid_q  <= gnt_id;
                wr_ptr <= wr_ptr + AW'(1);
                rr_ptr <= next_rr;
            end
        end
    end

    assign bus.in_ready   = ~slot_full;
    assign bus.o_we       = we_q;
    assign bus.o_addr     = addr_q;
    assign bus.o_data     = data_q;
    assign bus.grant_id   = gid_q;
    assign bus.lock_err   = err_q;
    assign bus.tx_pending = pend_q;
    assign bus.level      = level_q;
endmodule

// File: tb/tb_isa_tx_arbiter.sv
// Bench for isa_tx_arbiter: a cycle-level reference model built from the
// arbitration/lock rules, checked every cycle, plus literal expectations.
module tb_isa_tx_arbiter;
    localparam int N     = 4;
    localparam int AW    = 13;
    localparam int TO    = 255;
    localparam int DEPTH = 1 << AW;
    localparam int LOGSZ = 16384;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    isa_tx_arbiter_if #(.N(N), .AW(AW)) bus ();

    isa_tx_arbiter #(.N(N), .AW(AW), .LOCK_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    // reference model state
    typedef struct packed {
        logic [N-1:0]      full;
        logic [N-1:0][8:0] slot;
        logic [AW-1:0]     wr;
        logic [1:0]        rr;
        logic              locked;
        logic [1:0]        owner;
        logic [31:0]       cnt;
        logic              we;
        logic [AW-1:0]     addr;
        logic [8:0]        data;
        logic [1:0]        gid;
        logic              err;
        logic              pend;
        logic [AW-1:0]     level;
    } model_t;

    model_t m;

    function automatic model_t m_step(model_t s, logic [N-1:0] v, logic [9*N-1:0] d,
                                      logic [AW-1:0] rp);
        model_t n;
        int     g;
        int     i;
        n       = s;
        n.we    = 1'b0;
        n.err   = 1'b0;
        n.pend  = (int'(s.wr) != int'(rp));
        n.level = AW'((int'(s.wr) - int'(rp) + DEPTH) % DEPTH);
        g = -1;
        if (((int'(s.wr) + 1) % DEPTH) != int'(rp)) begin
            for (int k = 0; k < N; k++) begin
                i = (int'(s.rr) + k) % N;
                if (g < 0 && s.full[i] && (!s.locked || i == int'(s.owner))) g = i;
            end
        end
        if (g >= 0) begin
            n.we      = 1'b1;
            n.addr    = s.wr;
            n.data    = s.slot[g];
            n.gid     = 2'(g);
            n.wr      = AW'((int'(s.wr) + 1) % DEPTH);
            n.full[g] = 1'b0;
            n.rr      = 2'((g + 1) % N);
            if (s.slot[g][8]) begin
                n.locked = 1'b1;
                n.owner  = 2'(g);
                n.cnt    = 0;
            end else if (s.locked) begin
                n.locked = 1'b0;
                n.cnt    = 0;
            end
        end else if (s.locked && !s.full[s.owner]) begin
            n.cnt = s.cnt + 1;
            if (n.cnt == 32'(TO)) begin
                n.locked = 1'b0;
                n.cnt    = 0;
                n.err    = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (v[j] && !s.full[j]) begin
                n.full[j] = 1'b1;
                n.slot[j] = d[9*j +: 9];
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= m_step(m, bus.in_valid, bus.in_data, bus.rd_ptr);
    end

    // counters, write log
    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int nwr         = 0;
    int base        = 0;
    int nerr        = 0;
    int err_cyc     = 0;
    logic [AW-1:0] la [LOGSZ];
    logic [8:0]    ld [LOGSZ];
    logic [1:0]    lg [LOGSZ];
    int            lc [LOGSZ];

    // stimulus sources: scripted words first, then generated data-only words
    logic [8:0]   scr [N][8];
    int           scr_len [N];
    int           scr_pos [N];
    int           strm_left [N];
    int           strm_seq [N];
    logic [N-1:0] pend_acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic compare_cycle();
        logic [N-1:0] exp_rdy;
        cyc++;
        exp_rdy = ~m.full;
        chk("o_we", bus.o_we, m.we);
        chk("grant_id", bus.grant_id, m.gid);
        chk("lock_err", bus.lock_err, m.err);
        chk("tx_pending", bus.tx_pending, m.pend);
        chk("level", bus.level, m.level);
        chk("in_ready", bus.in_ready, exp_rdy);
        if (m.we) begin
            chk("o_addr", bus.o_addr, m.addr);
            chk("o_data", bus.o_data, m.data);
        end
        if (bus.o_we === 1'b1 && nwr < LOGSZ) begin
            la[nwr] = bus.o_addr;
            ld[nwr] = bus.o_data;
            lg[nwr] = bus.grant_id;
            lc[nwr] = cyc;
            nwr++;
        end
        if (bus.lock_err === 1'b1) begin
            nerr++;
            err_cyc = cyc;
        end
    endtask

    function automatic logic has_word(int i);
        return (scr_pos[i] < scr_len[i]) || (strm_left[i] > 0);
    endfunction

    function automatic logic [8:0] cur_word(int i);
        if (scr_pos[i] < scr_len[i]) return scr[i][scr_pos[i]];
        return {1'b0, 8'(strm_seq[i] * 4 + i)};
    endfunction

    task automatic pop(int i);
        if (scr_pos[i] < scr_len[i]) scr_pos[i]++;
        else begin
            strm_left[i]--;
            strm_seq[i]++;
        end
    endtask

    task automatic drive_step();
        for (int i = 0; i < N; i++) begin
            if (pend_acc[i]) pop(i);
            if (has_word(i)) begin
                bus.in_valid[i]       = 1'b1;
                bus.in_data[9*i +: 9] = cur_word(i);
            end else begin
                bus.in_valid[i]       = 1'b0;
                bus.in_data[9*i +: 9] = '0;
            end
        end
        pend_acc = bus.in_valid & bus.in_ready & {N{rst_n}};
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            scr_len[i]   = 0;
            scr_pos[i]   = 0;
            strm_left[i] = 0;
            strm_seq[i]  = 0;
        end
        pend_acc     = '0;
        bus.in_valid = '0;
        bus.in_data  = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        drive_step();
    endtask

    task automatic reset_dut();
        rst_n      = 1'b0;
        clear_src();
        bus.rd_ptr = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        base = nwr;
    endtask

    task automatic wait_writes(input int target, input int budget, input string nm);
        int k;
        k = 0;
        while ((nwr - base) < target && k < budget) begin
            tick();
            k++;
        end
        vectors++;
        if ((nwr - base) < target) begin
            miscompares++;
            $display("FAIL %s: only %0d writes, expected %0d", nm, nwr - base, target);
        end
    endtask

    initial begin
        int mk;
        int e0;
        int exp_a [5];
        exp_a = '{8191, 0, 1, 2, 3};
        clear_src();
        bus.rd_ptr = '0;
        tick();
        tick();
        // reset state
        chk("rst_o_we", bus.o_we, 0);
        chk("rst_o_addr", bus.o_addr, 0);
        chk("rst_o_data", bus.o_data, 0);
        chk("rst_grant_id", bus.grant_id, 0);
        chk("rst_lock_err", bus.lock_err, 0);
        chk("rst_tx_pending", bus.tx_pending, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_in_ready", bus.in_ready, 4'hF);
        rst_n = 1'b1;
        tick();
        base = nwr;

        // single marker word from requester 1
        scr[1][0]  = 9'h1A5;
        scr_len[1] = 1;
        tick();
        tick();
        chk("t1_in_ready", bus.in_ready, 4'b1101);
        chk("t1_no_we_yet", bus.o_we, 0);
        tick();
        chk("t1_o_we", bus.o_we, 1);
        chk("t1_o_addr", bus.o_addr, 0);
        chk("t1_o_data", bus.o_data, 9'h1A5);
        chk("t1_grant_id", bus.grant_id, 1);
        tick();
        chk("t1_tx_pending", bus.tx_pending, 1);
        chk("t1_level", bus.level, 1);

        // fairness: everyone streams data-only words
        reset_dut();
        for (int i = 0; i < N; i++) strm_left[i] = 3;
        wait_writes(12, 100, "t2_writes");
        for (int k = 0; k < 12; k++) begin
            chk("t2_gid_seq", lg[base + k], k % 4);
            chk("t2_addr_seq", la[base + k], k);
            chk("t2_data_seq", ld[base + k], k);
        end

        // marker/data pairing while requester 0 streams
        reset_dut();
        scr[2][0]    = 9'h188;
        scr[2][1]    = 9'h021;
        scr_len[2]   = 2;
        strm_left[0] = 4;
        wait_writes(6, 100, "t3_writes");
        chk("t3_first", ld[base], 9'h000);
        chk("t3_marker_data", ld[base + 1], 9'h188);
        chk("t3_marker_addr", la[base + 1], 1);
        chk("t3_pair_data", ld[base + 2], 9'h021);
        chk("t3_pair_addr", la[base + 2], 2);
        chk("t3_pair_gid", lg[base + 2], 2);
        chk("t3_pair_gap", lc[base + 2] - lc[base + 1], 2);
        chk("t3_resume_gid", lg[base + 3], 0);

        // lock timeout: requester 3 sends a marker and goes quiet
        reset_dut();
        e0         = nerr;
        scr[3][0]  = 9'h12C;
        scr_len[3] = 1;
        for (int i = 0; i < 3; i++) strm_left[i] = 20;
        wait_writes(61, 800, "t4_writes");
        tick();
        mk = -1;
        for (int k = 0; k < 61; k++) if (ld[base + k] == 9'h12C && mk < 0) mk = k;
        chk("t4_marker_index", mk, 3);
        if (mk < 0) mk = 3;
        chk("t4_err_count", nerr - e0, 1);
        chk("t4_err_delay", err_cyc - lc[base + mk], 255);
        chk("t4_resume_cycle", lc[base + mk + 1] - err_cyc, 1);

        // full ring and wrap
        reset_dut();
        for (int i = 0; i < N; i++) strm_left[i] = 2050;
        wait_writes(8191, 12000, "t5_fill");
        repeat (4) tick();
        chk("t5_writes_full", nwr - base, 8191);
        chk("t5_level_full", bus.level, 8191);
        chk("t5_in_ready_full", bus.in_ready, 0);
        chk("t5_o_we_full", bus.o_we, 0);
        bus.rd_ptr = AW'(5);
        wait_writes(8196, 60, "t5_wrap");
        repeat (4) tick();
        chk("t5_writes_wrap", nwr - base, 8196);
        for (int k = 0; k < 5; k++) chk("t5_wrap_addr", la[base + 8191 + k], exp_a[k]);
        chk("t5_level_wrap", bus.level, 8191);

        // async reset while locked with full slots
        reset_dut();
        scr[1][0]  = 9'h1FF;
        scr_len[1] = 1;
        strm_left[0] = 10;
        strm_left[2] = 10;
        strm_left[3] = 10;
        wait_writes(2, 50, "t6_marker");
        tick();
        tick();
        chk("t6_locked_ready", bus.in_ready, 4'b0010);
        chk("t6_locked_we", bus.o_we, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_o_we", bus.o_we, 0);
        chk("t6_rst_o_addr", bus.o_addr, 0);
        chk("t6_rst_o_data", bus.o_data, 0);
        chk("t6_rst_grant_id", bus.grant_id, 0);
        chk("t6_rst_tx_pending", bus.tx_pending, 0);
        chk("t6_rst_level", bus.level, 0);
        chk("t6_rst_in_ready", bus.in_ready, 4'hF);
        clear_src();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        base         = nwr;
        strm_left[0] = 1;
        wait_writes(1, 20, "t6_resume");
        chk("t6_first_addr", la[base], 0);
        chk("t6_first_data", ld[base], 9'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
